// File: rtl/ioctl_rom_packer.sv
// Packs the ioctl download byte stream into 16-bit words with byte strobes and
// writes them through a small FIFO to the program or graphics SDRAM port.
module ioctl_rom_packer #(
  parameter logic [24:0] GFX_BASE   = 25'h10000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        res_n_i,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        prg_req,
  input  logic        prg_ack,
  output logic [22:0] prg_a,
  output logic [15:0] prg_d,
  output logic [1:0]  prg_ds,
  output logic        gfx_req,
  input  logic        gfx_ack,
  output logic [22:0] gfx_a,
  output logic [15:0] gfx_d,
  output logic [1:0]  gfx_ds,
  output logic        rom_loaded,
  output logic        busy,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // SDRAM handshake: a write is requested by toggling req once; it is complete
  // when the port's ack equals its req. Only one write is outstanding at a time.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  logic        wr_q, dl_q, wr_edge, dl_rise, dl_fall;
  logic        in_v, retry_v, pend_v, done_once;
  logic [7:0]  in_d, retry_d, pend_d, src_d;
  logic [24:0] in_a, retry_a, pend_a, src_a;
  logic        src_v;

  logic        push, pend_load, pend_clr, retry_load;
  logic [24:0] push_byte_a, word_base;
  logic [15:0] push_d;
  logic [1:0]  push_ds;
  logic        push_gfx;
  logic        unused_bits;

  logic [41:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          empty, full, pop, do_push, drop;
  logic [41:0]   head;

  state_t state, state_nxt;
  logic   cur_gfx, cur_done, issue;

  assign wr_edge = ioctl_wr & ~wr_q & ioctl_download & ~ioctl_addr[24];
  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;

  // A byte deferred by a flush is served before the next captured byte.
  assign src_v = retry_v | in_v;
  assign src_d = retry_v ? retry_d : in_d;
  assign src_a = retry_v ? retry_a : in_a;

  always_comb begin
    push        = 1'b0;
    push_byte_a = src_a;
    push_d      = 16'h0000;
    push_ds     = 2'b00;
    pend_load   = 1'b0;
    pend_clr    = 1'b0;
    retry_load  = 1'b0;
    if (src_v) begin
      if (src_a[0] && pend_v && (src_a == pend_a + 25'd1)) begin
        push        = 1'b1;
        push_byte_a = pend_a;
        push_d      = {src_d, pend_d};
        push_ds     = 2'b11;
        pend_clr    = 1'b1;
      end else if (pend_v) begin
        push        = 1'b1;
        push_byte_a = pend_a;
        push_d      = {8'h00, pend_d};
        push_ds     = 2'b01;
        pend_clr    = 1'b1;
        retry_load  = 1'b1;
      end else if (src_a[0]) begin
        push    = 1'b1;
        push_d  = {src_d, 8'h00};
        push_ds = 2'b10;
      end else begin
        pend_load = 1'b1;
      end
    end else if (pend_v && !ioctl_download) begin
      push        = 1'b1;
      push_byte_a = pend_a;
      push_d      = {8'h00, pend_d};
      push_ds     = 2'b01;
      pend_clr    = 1'b1;
    end
  end

  assign push_gfx    = (push_byte_a >= GFX_BASE);
  assign word_base   = push_gfx ? (push_byte_a - GFX_BASE) : push_byte_a;
  assign unused_bits = ^{word_base[24], word_base[0]};

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) begin
      wr_q      <= 1'b0;
      dl_q      <= 1'b0;
      in_v      <= 1'b0;
      in_d      <= 8'h00;
      in_a      <= 25'd0;
      retry_v   <= 1'b0;
      retry_d   <= 8'h00;
      retry_a   <= 25'd0;
      pend_v    <= 1'b0;
      pend_d    <= 8'h00;
      pend_a    <= 25'd0;
      done_once <= 1'b0;
    end else begin
      wr_q    <= ioctl_wr;
      dl_q    <= ioctl_download;
      in_v    <= wr_edge;
      retry_v <= retry_load;
      if (wr_edge) begin
        in_d <= ioctl_dout;
        in_a <= ioctl_addr;
      end
      if (retry_load) begin
        retry_d <= src_d;
        retry_a <= src_a;
      end
      if (pend_load) begin
        pend_v <= 1'b1;
        pend_d <= src_d;
        pend_a <= src_a;
      end else if (pend_clr) begin
        pend_v <= 1'b0;
      end
      if (dl_fall) done_once <= 1'b1;
    end
  end

  // FIFO: a push into a full FIFO only succeeds when the head leaves in the same cycle.
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign head    = mem[rptr];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wptr] <= {push_gfx, word_base[23:1], push_d, push_ds};
  end

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign cur_done = cur_gfx ? (gfx_ack == gfx_req) : (prg_ack == prg_req);

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cur_done) state_nxt = empty ? S_IDLE : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    issue = 1'b0;
    case (state)
      S_IDLE:  pop   = ~empty;
      S_ISSUE: issue = 1'b1;
      S_WAIT:  pop   = cur_done & ~empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) begin
      cur_gfx    <= 1'b0;
      prg_req    <= 1'b0;
      prg_a      <= 23'd0;
      prg_d      <= 16'h0000;
      prg_ds     <= 2'b00;
      gfx_req    <= 1'b0;
      gfx_a      <= 23'd0;
      gfx_d      <= 16'h0000;
      gfx_ds     <= 2'b00;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (pop) begin
        cur_gfx <= head[41];
        if (head[41]) begin
          gfx_a  <= head[40:18];
          gfx_d  <= head[17:2];
          gfx_ds <= head[1:0];
        end else begin
          prg_a  <= head[40:18];
          prg_d  <= head[17:2];
          prg_ds <= head[1:0];
        end
      end
      if (issue) begin
        if (cur_gfx) gfx_req <= ~gfx_req;
        else         prg_req <= ~prg_req;
      end
      if (dl_rise) rom_loaded <= 1'b0;
      else if (done_once && !ioctl_download && !in_v && !retry_v && !pend_v &&
               empty && (state == S_IDLE))
        rom_loaded <= 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (dl_rise) overflow <= 1'b0;
    end
  end

  assign busy = res_n_i & (ioctl_download | in_v | retry_v | pend_v | ~empty |
                           (state != S_IDLE));
endmodule

// File: tb/tb_ioctl_rom_packer.sv
// Randomized and directed bench for ioctl_rom_packer against a byte-level packing model.
module tb_ioctl_rom_packer;
  localparam logic [24:0] GFX_BASE = 25'h10000;

  logic        clk_sys, res_n_i;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        prg_req, prg_ack, gfx_req, gfx_ack;
  logic [22:0] prg_a, gfx_a;
  logic [15:0] prg_d, gfx_d;
  logic [1:0]  prg_ds, gfx_ds;
  logic        rom_loaded, busy, overflow;

  ioctl_rom_packer #(.GFX_BASE(GFX_BASE), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .res_n_i(res_n_i),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .prg_req(prg_req), .prg_ack(prg_ack), .prg_a(prg_a), .prg_d(prg_d), .prg_ds(prg_ds),
    .gfx_req(gfx_req), .gfx_ack(gfx_ack), .gfx_a(gfx_a), .gfx_d(gfx_d), .gfx_ds(gfx_ds),
    .rom_loaded(rom_loaded), .busy(busy), .overflow(overflow)
  );

  // clock / reset
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_prg = 0;
  int n_gfx = 0;
  int ack_delay = 5;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // reference model: expected writes as {gfx, word_addr, data, ds}
  logic [41:0] exp_q[$];
  logic        m_pend_v = 1'b0;
  logic [24:0] m_pend_a = 25'd0;
  logic [7:0]  m_pend_d = 8'h00;

  task automatic emit(input logic [24:0] a, input logic [15:0] d, input logic [1:0] ds);
    logic        g;
    logic [24:0] off;
    g   = (a >= GFX_BASE);
    off = g ? (a - GFX_BASE) : a;
    off = off >> 1;
    exp_q.push_back({g, off[22:0], d, ds});
  endtask

  task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
    if (a[24]) return;
    if (a[0] && m_pend_v && (a == m_pend_a + 25'd1)) begin
      emit(m_pend_a, {d, m_pend_d}, 2'b11);
      m_pend_v = 1'b0;
      return;
    end
    if (m_pend_v) begin
      emit(m_pend_a, {8'h00, m_pend_d}, 2'b01);
      m_pend_v = 1'b0;
    end
    if (a[0]) emit(a, {d, 8'h00}, 2'b10);
    else begin
      m_pend_v = 1'b1;
      m_pend_a = a;
      m_pend_d = d;
    end
  endtask

  task automatic model_end();
    if (m_pend_v) emit(m_pend_a, {8'h00, m_pend_d}, 2'b01);
    m_pend_v = 1'b0;
  endtask

  // SDRAM responder: echoes req onto ack after ack_delay cycles
  int prg_cnt = 0;
  int gfx_cnt = 0;
  always @(negedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) begin
      prg_ack = 1'b0; gfx_ack = 1'b0; prg_cnt = 0; gfx_cnt = 0;
    end else begin
      if (prg_req != prg_ack) begin
        if (prg_cnt >= ack_delay) begin prg_ack = prg_req; prg_cnt = 0; end
        else prg_cnt++;
      end
      if (gfx_req != gfx_ack) begin
        if (gfx_cnt >= ack_delay) begin gfx_ack = gfx_req; gfx_cnt = 0; end
        else gfx_cnt++;
      end
    end
  end

  // scoreboard: every req toggle is one write, compared against the model in order
  logic prg_last, gfx_last;

  task automatic score(input logic [41:0] got);
    logic [41:0] e;
    if (exp_q.size() == 0) check("unexpected_write", 64'(got), 64'h0);
    else begin
      e = exp_q.pop_front();
      check("write", 64'(got), 64'(e));
    end
  endtask

  always @(negedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) begin
      prg_last = 1'b0; gfx_last = 1'b0;
    end else begin
      if (prg_req !== prg_last) begin
        prg_last = prg_req;
        n_prg++;
        check("single_outstanding_prg", 64'(gfx_req ^ gfx_ack), 64'h0);
        score({1'b0, prg_a, prg_d, prg_ds});
      end
      if (gfx_req !== gfx_last) begin
        gfx_last = gfx_req;
        n_gfx++;
        check("single_outstanding_gfx", 64'(prg_req ^ prg_ack), 64'h0);
        score({1'b1, gfx_a, gfx_d, gfx_ds});
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
    @(negedge clk_sys);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    model_byte(a, d);
    repeat (2) @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic start_download();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_download();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    model_end();
  endtask

  task automatic wait_loaded(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (rom_loaded) break;
    end
    check(tag, 64'(rom_loaded), 64'h1);
    check({tag, "_all_written"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_prg"}, 64'({prg_req, prg_a, prg_d, prg_ds}), 64'h0);
    check({tag, "_gfx"}, 64'({gfx_req, gfx_a, gfx_d, gfx_ds}), 64'h0);
    check({tag, "_flags"}, 64'({rom_loaded, busy, overflow}), 64'h0);
  endtask

  int base_prg, base_gfx, lat;
  logic r0;
  logic [24:0] cur;

  initial begin
    res_n_i = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);
    check_outputs_zero("reset");
    res_n_i = 1'b1;
    repeat (2) @(negedge clk_sys);

    // four sequential program bytes, with a latency check on the completing byte
    ack_delay = 5;
    base_prg = n_prg;
    start_download();
    send_byte(25'd0, 8'h11, 3);
    @(negedge clk_sys);
    ioctl_addr = 25'd1; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
    model_byte(25'd1, 8'h22);
    r0 = prg_req;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      lat++;
      if (lat == 2) ioctl_wr = 1'b0;
      if (prg_req != r0) break;
    end
    check("req_latency", 64'(lat), 64'd4);
    repeat (3) @(negedge clk_sys);
    send_byte(25'd2, 8'h33, 3);
    send_byte(25'd3, 8'h44, 3);
    check("loaded_low_during_download", 64'(rom_loaded), 64'h0);
    end_download();
    wait_loaded("s1_loaded", 200);
    check("s1_prg_count", 64'(n_prg - base_prg), 64'd2);
    check("s1_last_word", 64'({prg_a, prg_d, prg_ds}), 64'({23'd1, 16'h4433, 2'b11}));

    // graphics word
    base_prg = n_prg; base_gfx = n_gfx;
    start_download();
    send_byte(25'h10000, 8'hAB, 3);
    send_byte(25'h10001, 8'hCD, 3);
    end_download();
    wait_loaded("s2_loaded", 200);
    check("s2_prg_count", 64'(n_prg - base_prg), 64'd0);
    check("s2_gfx_count", 64'(n_gfx - base_gfx), 64'd1);

    // single odd byte, then single even byte
    start_download();
    send_byte(25'd7, 8'h5A, 3);
    end_download();
    wait_loaded("s3a_loaded", 200);
    check("s3a_word", 64'({prg_a, prg_d, prg_ds}), 64'({23'd3, 16'h5A00, 2'b10}));
    start_download();
    send_byte(25'd4, 8'h77, 3);
    end_download();
    wait_loaded("s3b_loaded", 200);
    check("s3b_word", 64'({prg_a, prg_d, prg_ds}), 64'({23'd2, 16'h0077, 2'b01}));

    // overflow: ack held off while six words arrive
    ack_delay = 200;
    base_prg = n_prg;
    start_download();
    for (int i = 0; i < 12; i++) send_byte(25'h200 + 25'(i), 8'($urandom_range(0, 255)), 2);
    check("overflow_set", 64'(overflow), 64'h1);
    end_download();
    void'(exp_q.pop_back());
    wait_loaded("s4_loaded", 3000);
    check("s4_prg_count", 64'(n_prg - base_prg), 64'd5);
    ack_delay = 3;
    start_download();
    check("overflow_cleared", 64'(overflow), 64'h0);
    check("loaded_cleared", 64'(rom_loaded), 64'h0);
    end_download();
    wait_loaded("s4b_loaded", 200);

    // reset during WAIT
    ack_delay = 50;
    base_prg = n_prg;
    start_download();
    send_byte(25'h20, 8'h12, 3);
    send_byte(25'h21, 8'h34, 3);
    for (int i = 0; i < 100; i++) begin
      if (n_prg != base_prg) break;
      @(negedge clk_sys);
    end
    check("s5_write_seen", 64'(n_prg - base_prg), 64'd1);
    repeat (3) @(negedge clk_sys);
    #2;
    res_n_i = 1'b0; ioctl_download = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk_sys);
    #2;
    res_n_i = 1'b1;
    m_pend_v = 1'b0;
    check("s5_queue_empty", 64'(exp_q.size()), 64'h0);
    ack_delay = 5;
    base_prg = n_prg;
    start_download();
    send_byte(25'h30, 8'h99, 3);
    send_byte(25'h31, 8'h88, 3);
    end_download();
    wait_loaded("s5_loaded", 200);
    check("s5_prg_count", 64'(n_prg - base_prg), 64'd1);

    // region boundary: two partial words on different ports
    base_gfx = n_gfx;
    start_download();
    send_byte(25'h0FFFF, 8'hE1, 3);
    send_byte(25'h10000, 8'hE2, 3);
    end_download();
    for (int i = 0; i < 100; i++) begin
      if (n_gfx != base_gfx) break;
      @(negedge clk_sys);
    end
    check("s6_busy_until_ack", 64'(busy), 64'h1);
    wait_loaded("s6_loaded", 200);
    check("s6_busy_done", 64'(busy), 64'h0);

    // randomized runs across the region boundary, with ignored bytes mixed in
    for (int r = 0; r < 3; r++) begin
      ack_delay = $urandom_range(1, 6);
      start_download();
      cur = 25'h0FFF0 + 25'($urandom_range(0, 31));
      for (int i = 0; i < 24; i++) begin
        send_byte(cur, 8'($urandom_range(0, 255)), $urandom_range(18, 24));
        case ($urandom_range(0, 9))
          0, 1:    cur = 25'h0FFF0 + 25'($urandom_range(0, 31));
          2:       cur = 25'h1000000 | 25'($urandom_range(0, 255));
          default: cur = (cur[24] ? 25'h0FFF0 : cur) + 25'd1;
        endcase
      end
      end_download();
      wait_loaded("rand_loaded", 1000);
      check("rand_no_overflow", 64'(overflow), 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ioctl_rom_packer.md
Name: ioctl_rom_packer

Overview:
- Sits between the SPI data_io download port and the SDRAM controller's two write ports.
- Packs the ioctl byte stream into 16-bit words with byte strobes.
- Splits words into a program region and a graphics region, queues them in a small FIFO, and issues toggle-style req/ack writes to the matching SDRAM port.
- Asserts rom_loaded once the download has ended and every byte has been committed; the system reset is derived from this flag.

Parameters:
- GFX_BASE, 25'h10000: byte address where the graphics region begins. Bytes at or above it go to the gfx port.
- FIFO_DEPTH, 4: number of word entries buffered. Power of two, minimum 2.

Ports:
- clk_sys  in  1  block clock; all logic on its rising edge
- res_n_i  in  1  reset, asynchronous, active-low
- ioctl_download  in  1  high while a download is in progress
- ioctl_wr  in  1  byte write strobe; level, may last several cycles
- ioctl_addr  in  25  byte address of ioctl_dout
- ioctl_dout  in  8  download byte
- prg_req  out  1  program port request toggle
- prg_ack  in  1  program port acknowledge toggle
- prg_a  out  23  program word address
- prg_d  out  16  program write data
- prg_ds  out  2  program byte strobes: [1] high byte, [0] low byte
- gfx_req  out  1  graphics port request toggle
- gfx_ack  in  1  graphics port acknowledge toggle
- gfx_a  out  23  graphics word address, relative to GFX_BASE
- gfx_d  out  16  graphics write data
- gfx_ds  out  2  graphics byte strobes
- rom_loaded  out  1  all bytes of the last download committed
- busy  out  1  download active or write work outstanding
- overflow  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (res_n_i low, asynchronous): every output is 0, the FIFO is empty, there is no pending byte, and the FSM is IDLE. After reset the SDRAM side presents ack = 0.
- Byte capture: a byte is accepted on the first cycle ioctl_wr is seen high after being low, while ioctl_download = 1. ioctl_wr is registered once for edge detection. Bytes with ioctl_addr[24] = 1 are ignored.
- Region and word address:
  - Region is gfx when ioctl_addr >= GFX_BASE.
  - Program word address = ioctl_addr[23:1].
  - Graphics word address = (ioctl_addr - GFX_BASE)[23:1], using 25-bit subtraction.
- Packing, with one pending-byte register holding data, address and valid:
  - Even byte with no pending byte: stored as pending.
  - Odd byte whose address equals pending address + 1: pushes a full word. Data = {odd, even}, ds = 2'b11. Pending is cleared.
  - Odd byte with no matching pending byte: pushes {byte, 8'h00} with ds = 2'b10.
  - New even byte, or a non-consecutive byte, while a byte is pending: first flush pending as {8'h00, pend} with ds = 2'b01. The new byte is handled on the next cycle; ioctl_wr edges are at least 2 cycles apart by data_io contract.
  - Falling edge of ioctl_download with a byte pending: flush it as a partial word.
- FIFO: entries hold {region, word_addr, data, ds}.
  - A push is visible to the FSM on the following cycle.
  - Push while full: the word is dropped and overflow is set.
  - Simultaneous push and pop while full: both succeed; no drop.
- Issue FSM:
  - IDLE: if the FIFO is not empty, pop the head, drive a/d/ds on the selected port, go to ISSUE.
  - ISSUE: toggle that port's req once, go to WAIT.
  - WAIT: stay until that port's ack equals its req, then return to IDLE. The next pop can happen in the same cycle.
  - Only one request is outstanding across both ports. a/d/ds stay stable from ISSUE until ack matches. The unused port's outputs hold their last values.
- Latency: completing ioctl_wr edge sampled at cycle N → FIFO push at N+1 → req toggles at N+3 when the FIFO was empty and the FSM was IDLE.
- Download start (rising ioctl_download): clears rom_loaded and overflow. The FIFO and any in-flight write are not disturbed.
- rom_loaded: set on the first cycle where ioctl_download = 0, no byte is pending, the FIFO is empty and the FSM is IDLE, provided at least one download has completed since reset. Held until the next download start.
- busy = ioctl_download | pending valid | FIFO not empty | (FSM != IDLE).
- Reset asserted mid-transfer: everything is abandoned immediately and rom_loaded = 0. The SDRAM controller is reset together with this block.

Test Plan:
- Sequential bytes to addresses 0..3 = 11,22,33,44 with ack echoing req after 5 cycles → two prg writes: (a=0, d=16'h2211, ds=11), then (a=1, d=16'h4433, ds=11); rom_loaded rises after the final ack once download drops.
- Byte 0xAB at address 0x10000, then 0xCD at 0x10001 → one gfx write (a=0, d=16'hCDAB, ds=11); prg_req never toggles.
- Single byte 0x5A at address 7, then download ends → prg write (a=3, d=16'h5A00, ds=10). Single byte 0x77 at address 4, then download ends → prg write (a=2, d=16'h0077, ds=01).
- Hold ack for 200 cycles while feeding 12 bytes (6 words) → FIFO fills, overflow = 1, exactly 5 words written (1 in flight + 4 queued); overflow clears on the next download start.
- Pulse res_n_i low during WAIT → all outputs 0 asynchronously, within the same cycle; after release, a fresh download of 2 bytes yields exactly one write.
- Interleave bytes at 0x0FFFF then 0x10000 → a prg partial write (ds=10) and a gfx partial write (ds=01); busy stays high until the second ack.
